clk_period_meter: RTL

CLK_PERIOD_METER -- requirements
Module: clk_period_meter

---
 rtl/clk_period_meter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/clk_period_meter.sv
`timescale 1ns/1ps
// Measures the period and high time of a slow square wave in core clock cycles.
// Latency: results appear 3 clk cycles after the sig_in rising edge that closes a period.
// No backpressure: valid is a single-cycle strobe, outputs hold until the next strobe.
//
// Ports:
//   clk, reset         - system clock, asynchronous active-high reset
//   sig_in             - asynchronous square wave under measurement
//   enable             - 1 = measure, 0 = abort and idle
//   clr_ovf            - synchronous clear of the sticky overflow flag
//   period, high_time  - last complete rising-to-rising period and its high portion
//   valid              - one-cycle pulse when period/high_time update
//   overflow           - sticky flag, set when the counter saturates mid-measurement
module clk_period_meter #(
    parameter int WIDTH = 26
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sig_in,
    input  logic             enable,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             valid,
    output logic             overflow
);

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    state_t state_q, state_d;

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic dly_q, dly_d;

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_cap_q, hi_cap_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] high_time_q, high_time_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;

    logic rise;
    logic fall;
    logic sat;

    // Edge detection on the synchronized copy against its one-cycle-late copy.
    assign rise = sync2_q & ~dly_q;
    assign fall = ~sync2_q & dly_q;

    // Saturation only matters if this cycle does not also close the period;
    // a rise with the counter at all-ones is a normal completion.
    assign sat = (state_q == MEASURE) && (cnt_q == CNT_MAX) && !rise;

    // Synchronizer chain plus delay flop.
    always_comb begin
        sync1_d = sig_in;
        sync2_d = sync1_q;
        dly_d   = sync2_q;
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (rise) state_d = MEASURE;
                MEASURE: if (sat)  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Output / datapath logic.
    always_comb begin
        cnt_d       = cnt_q;
        hi_cap_d    = hi_cap_q;
        period_d    = period_q;
        high_time_d = high_time_q;
        valid_d     = 1'b0;
        // Clear first so that a saturation later in this block overrides it.
        ovf_d       = clr_ovf ? 1'b0 : ovf_q;

        if (!enable) begin
            cnt_d    = '0;
            hi_cap_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // The arming edge starts the count but produces no result.
                    cnt_d = rise ? CNT_ONE : '0;
                end
                MEASURE: begin
                    if (rise) begin
                        period_d    = cnt_q;
                        high_time_d = hi_cap_q;
                        valid_d     = 1'b1;
                        cnt_d       = CNT_ONE;
                    end else if (sat) begin
                        ovf_d = 1'b1;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                        if (fall) begin
                            hi_cap_d = cnt_q;
                        end
                    end
                end
                default: begin
                    cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            dly_q       <= 1'b0;
            cnt_q       <= '0;
            hi_cap_q    <= '0;
            period_q    <= '0;
            high_time_q <= '0;
            valid_q     <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            dly_q       <= dly_d;
            cnt_q       <= cnt_d;
            hi_cap_q    <= hi_cap_d;
            period_q    <= period_d;
            high_time_q <= high_time_d;
            valid_q     <= valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign period    = period_q;
    assign high_time = high_time_q;
    assign valid     = valid_q;
    assign overflow  = ovf_q;

endmodule
